// File: rtl/song_sequencer_pkg.sv
// Shared definitions for the song sequencer: ROM geometry, row-word field layout
// and the sequencer state encoding.
package song_sequencer_pkg;

    localparam int ROM_ADDR_W = 8;
    localparam int ROM_DATA_W = 16;

    localparam int ROW_INSTR_MSB  = 15;
    localparam int ROW_INSTR_LSB  = 12;
    localparam int ROW_KEY_ON_BIT = 11;
    localparam int ROW_LOOP_BIT   = 10;
    localparam int ROW_NOTE_MSB   = 5;
    localparam int ROW_NOTE_LSB   = 0;

    localparam int INSTR_W    = ROW_INSTR_MSB - ROW_INSTR_LSB + 1;
    localparam int NOTE_W     = ROW_NOTE_MSB - ROW_NOTE_LSB + 1;
    localparam int TICK_CNT_W = 4;

    typedef struct packed {
        logic [INSTR_W-1:0] instrument;
        logic               key_on;
        logic               loop;
        logic [3:0]         reserved;
        logic [NOTE_W-1:0]  note;
    } row_word_t;

    typedef enum logic [2:0] {
        ST_WAIT_TICK,
        ST_ROW_ADDR,
        ST_READ_ROW,
        ST_EMIT,
        ST_STROBE
    } seq_state_t;

endpackage

// File: rtl/song_sequencer_frame_divider.sv
// Counts accepted frame ticks modulo TICKS_PER_ROW; row_due flags the tick that
// starts a new row.
module frame_divider
    import song_sequencer_pkg::*;
#(
    parameter int unsigned TICKS_PER_ROW = 6
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_advance,
    output logic o_row_due
);

    localparam logic [TICK_CNT_W-1:0] LAST_TICK = TICK_CNT_W'(TICKS_PER_ROW - 1);

    logic [TICK_CNT_W-1:0] tick_cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tick_cnt_q <= '0;
        end else if (i_clear) begin
            tick_cnt_q <= '0;
        end else if (i_advance) begin
            tick_cnt_q <= (tick_cnt_q == LAST_TICK) ? '0 : tick_cnt_q + 1'b1;
        end
    end

    assign o_row_due = (tick_cnt_q == '0);

endmodule

// File: rtl/song_sequencer.sv
// Song sequencer: on frame ticks, fetches one row word every TICKS_PER_ROW ticks
// and issues instrument-load, note and strobe pulses to the envelope generator.
module song_sequencer
    import song_sequencer_pkg::*;
#(
    parameter logic [ROM_ADDR_W-1:0] BASE_ADDRESS  = 8'h40,
    parameter int unsigned           SONG_LENGTH   = 64,
    parameter int unsigned           TICKS_PER_ROW = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_enable,
    input  logic                  i_restart,
    input  logic                  i_frame_tick,
    output logic [ROM_ADDR_W-1:0] o_rom_addr,
    input  logic [ROM_DATA_W-1:0] i_rom_data,
    output logic                  o_load_instrument,
    output logic [INSTR_W-1:0]    o_instrument,
    output logic                  o_strobe,
    output logic                  o_note_valid,
    output logic [NOTE_W-1:0]     o_note,
    output logic [ROM_ADDR_W-1:0] o_row,
    output logic                  o_overrun
);

    localparam logic [ROM_ADDR_W-1:0] LAST_ROW = ROM_ADDR_W'(SONG_LENGTH - 1);

    seq_state_t            state_q, state_d;
    logic                  row_due;
    logic                  tick_valid;
    row_word_t             row_w;
    logic                  unused_reserved;
    logic [ROM_ADDR_W-1:0] row_q;
    logic                  key_on_q;
    logic [INSTR_W-1:0]    instr_q;
    logic [NOTE_W-1:0]     note_q;
    logic                  overrun_q;

    assign row_w           = row_word_t'(i_rom_data);
    assign unused_reserved = ^row_w.reserved;
    // Restart outranks a coincident tick, so such a tick is neither accepted nor an overrun.
    assign tick_valid      = i_frame_tick & i_enable & ~i_restart;

    frame_divider #(
        .TICKS_PER_ROW(TICKS_PER_ROW)
    ) u_frame_divider (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (i_restart),
        .i_advance (state_q == ST_STROBE),
        .o_row_due (row_due)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_WAIT_TICK;
        end else if (i_restart) begin
            state_q <= ST_WAIT_TICK;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT_TICK: if (tick_valid) state_d = row_due ? ST_ROW_ADDR : ST_STROBE;
            ST_ROW_ADDR:  state_d = ST_READ_ROW;
            ST_READ_ROW:  state_d = ST_EMIT;
            ST_EMIT:      state_d = ST_STROBE;
            ST_STROBE:    state_d = ST_WAIT_TICK;
            default:      state_d = ST_WAIT_TICK;
        endcase
    end

    always_comb begin
        o_rom_addr        = '0;
        o_load_instrument = 1'b0;
        o_note_valid      = 1'b0;
        o_strobe          = 1'b0;
        case (state_q)
            ST_ROW_ADDR: o_rom_addr = BASE_ADDRESS + row_q;
            ST_EMIT: begin
                o_load_instrument = key_on_q;
                o_note_valid      = key_on_q;
            end
            ST_STROBE:   o_strobe = 1'b1;
            default:     ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            row_q     <= '0;
            key_on_q  <= 1'b0;
            instr_q   <= '0;
            note_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (tick_valid && state_q != ST_WAIT_TICK) begin
                overrun_q <= 1'b1;
            end
            if (i_restart) begin
                row_q    <= '0;
                key_on_q <= 1'b0;
            end else if (state_q == ST_READ_ROW) begin
                key_on_q <= row_w.key_on;
                row_q    <= (row_w.loop || row_q == LAST_ROW) ? '0 : row_q + 8'd1;
                if (row_w.key_on) begin
                    instr_q <= row_w.instrument;
                    note_q  <= row_w.note;
                end
            end
        end
    end

    assign o_instrument = instr_q;
    assign o_note       = note_q;
    assign o_row        = row_q;
    assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: two instances (default and SONG_LENGTH=4/TICKS_PER_ROW=1)
// checked every cycle against a timeline model, plus directed literal checks.
module tb_song_sequencer;

    localparam logic [7:0] BASE = 8'h40;
    localparam int         SL [2] = '{64, 4};
    localparam int         TPR[2] = '{6, 1};

    logic       clk, rst_n, enable, restart, frame_tick;
    logic [7:0] rom_addr [2];
    logic [15:0] rom_data [2];
    logic       load [2];
    logic [3:0] instr [2];
    logic       strobe [2];
    logic       nv [2];
    logic [5:0] note [2];
    logic [7:0] row [2];
    logic       ovr [2];

    logic [15:0] rom [2][256];

    int n_tests = 0;
    int n_fail  = 0;

    song_sequencer #(.BASE_ADDRESS(8'h40), .SONG_LENGTH(64), .TICKS_PER_ROW(6)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_restart(restart),
        .i_frame_tick(frame_tick), .o_rom_addr(rom_addr[0]), .i_rom_data(rom_data[0]),
        .o_load_instrument(load[0]), .o_instrument(instr[0]), .o_strobe(strobe[0]),
        .o_note_valid(nv[0]), .o_note(note[0]), .o_row(row[0]), .o_overrun(ovr[0]));

    song_sequencer #(.BASE_ADDRESS(8'h40), .SONG_LENGTH(4), .TICKS_PER_ROW(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_restart(restart),
        .i_frame_tick(frame_tick), .o_rom_addr(rom_addr[1]), .i_rom_data(rom_data[1]),
        .o_load_instrument(load[1]), .o_instrument(instr[1]), .o_strobe(strobe[1]),
        .o_note_valid(nv[1]), .o_note(note[1]), .o_row(row[1]), .o_overrun(ovr[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM: data for an address appears the cycle after it is presented.
    always @(posedge clk) begin
        rom_data[0] <= rom[0][rom_addr[0]];
        rom_data[1] <= rom[1][rom_addr[1]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- timeline model ----------------
    typedef struct packed {
        logic [7:0] addr;
        logic       load;
        logic       strobe;
        logic       upd;
        logic [7:0] new_row;
        logic       key;
        logic [3:0] instr;
        logic [5:0] note;
    } ent_t;

    ent_t       sched [2][8];
    int         sched_len [2];
    int         m_row [2];
    int         m_tick [2];
    logic [7:0] h_row [2];
    logic [3:0] h_instr [2];
    logic [5:0] h_note [2];
    logic       h_ovr [2];

    function automatic void push(input int k, input ent_t e);
        sched[k][sched_len[k]] = e;
        sched_len[k]++;
    endfunction

    function automatic void pop(input int k);
        for (int i = 0; i < 7; i++) sched[k][i] = sched[k][i+1];
        sched_len[k]--;
    endfunction

    function automatic void model_reset(input int k);
        sched_len[k] = 0;
        m_row[k]  = 0;
        m_tick[k] = 0;
        h_row[k]  = '0;
        h_instr[k] = '0;
        h_note[k] = '0;
        h_ovr[k]  = 1'b0;
    endfunction

    always @(negedge clk) begin
        ent_t        cur;
        ent_t        e;
        logic [15:0] w;
        int          nr;
        bit          busy;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) model_reset(k);
            cur = (sched_len[k] != 0) ? sched[k][0] : '0;
            check($sformatf("u%0d_rom_addr", k), rom_addr[k], cur.addr);
            check($sformatf("u%0d_load", k), load[k], cur.load);
            check($sformatf("u%0d_note_valid", k), nv[k], cur.load);
            check($sformatf("u%0d_strobe", k), strobe[k], cur.strobe);
            check($sformatf("u%0d_instrument", k), instr[k], h_instr[k]);
            check($sformatf("u%0d_note", k), note[k], h_note[k]);
            check($sformatf("u%0d_row", k), row[k], h_row[k]);
            check($sformatf("u%0d_overrun", k), ovr[k], h_ovr[k]);
            if (rst_n) begin
                busy = (sched_len[k] != 0);
                if (restart) begin
                    sched_len[k] = 0;
                    m_row[k]  = 0;
                    m_tick[k] = 0;
                    h_row[k]  = '0;
                end else begin
                    if (busy) pop(k);
                    if (frame_tick && enable) begin
                        if (busy) begin
                            h_ovr[k] = 1'b1;
                        end else begin
                            if (m_tick[k] == 0) begin
                                w  = rom[k][8'(int'(BASE) + m_row[k])];
                                nr = (w[10] || m_row[k] == SL[k] - 1) ? 0 : m_row[k] + 1;
                                e = '0; e.addr = 8'(int'(BASE) + m_row[k]); push(k, e);
                                e = '0; push(k, e);
                                e = '0; e.load = w[11]; e.upd = 1'b1; e.new_row = 8'(nr);
                                e.key = w[11]; e.instr = w[15:12]; e.note = w[5:0]; push(k, e);
                                e = '0; e.strobe = 1'b1; push(k, e);
                                m_row[k] = nr;
                            end else begin
                                e = '0; e.strobe = 1'b1; push(k, e);
                            end
                            m_tick[k] = (m_tick[k] + 1) % TPR[k];
                        end
                    end
                    if (sched_len[k] != 0 && sched[k][0].upd) begin
                        h_row[k] = sched[k][0].new_row;
                        if (sched[k][0].key) begin
                            h_instr[k] = sched[k][0].instr;
                            h_note[k]  = sched[k][0].note;
                        end
                    end
                end
            end
        end
    end

    // ---------------- event tallies for directed checks ----------------
    int         cnt_fetch, cnt_strobe, cnt_load, cnt_fetch1;
    logic [7:0] last_addr;

    always @(negedge clk) begin
        if (rst_n) begin
            if (rom_addr[0] != 8'h00) begin
                cnt_fetch++;
                last_addr = rom_addr[0];
            end
            if (rom_addr[1] != 8'h00) cnt_fetch1++;
            if (strobe[0]) cnt_strobe++;
            if (load[0])   cnt_load++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
    endtask

    task automatic tick_and_idle();
        pulse_tick();
        repeat (5) cyc();
    endtask

    task automatic clear_tallies();
        cnt_fetch = 0; cnt_strobe = 0; cnt_load = 0; cnt_fetch1 = 0; last_addr = 8'h00;
    endtask

    int s;

    initial begin
        for (int i = 0; i < 256; i++) begin
            rom[0][i] = 16'($urandom);
            if ($urandom_range(0, 7) != 0) rom[0][i][10] = 1'b0;
            rom[1][i] = 16'($urandom) & 16'hFBFF;
        end
        rom[0][8'h40] = 16'h3805;
        rom[0][8'h41] = 16'h7021;
        rom[0][8'h42] = 16'h0C00;
        rom[1][8'h40] = 16'h3805;
        for (int k = 0; k < 2; k++) model_reset(k);
        rst_n = 1'b0; enable = 1'b0; restart = 1'b0; frame_tick = 1'b0;
        clear_tallies();
        repeat (3) cyc();
        @(negedge clk);
        check("reset_row", row[0], 8'h00);
        check("reset_instr", instr[0], 4'h0);
        check("reset_overrun", ovr[0], 1'b0);
        cyc();
        rst_n = 1'b1;
        cyc();
        enable = 1'b1;
        clear_tallies();

        // first row tick latency
        pulse_tick();
        @(negedge clk);
        check("t1_addr_c1", rom_addr[0], 8'h40);
        cyc(); cyc();
        @(negedge clk);
        check("t1_load_c3", load[0], 1'b1);
        check("t1_nv_c3", nv[0], 1'b1);
        check("t1_instr", instr[0], 4'h3);
        check("t1_note", note[0], 6'h05);
        cyc();
        @(negedge clk);
        check("t1_strobe_c4", strobe[0], 1'b1);
        cyc();

        // rows 0..1 over 12 ticks; row 1 has key_on clear
        repeat (11) tick_and_idle();
        check("t2_fetches", cnt_fetch, 2);
        check("t2_strobes", cnt_strobe, 12);
        check("t2_loads", cnt_load, 1);
        check("t2_last_addr", last_addr, 8'h41);
        check("t2_row", row[0], 8'h02);
        check("t4_instr_hold", instr[0], 4'h3);
        check("t4_note_hold", note[0], 6'h05);
        check("t3_len4_row", row[1], 8'h00);
        check("t3_tpr1_fetches", cnt_fetch1, 12);

        // loop bit on row 2
        tick_and_idle();
        check("t3_loop_row", row[0], 8'h00);
        repeat (5) tick_and_idle();
        last_addr = 8'h00;
        tick_and_idle();
        check("t3_refetch", last_addr, 8'h40);

        // disabled tick
        enable = 1'b0;
        s = cnt_strobe;
        tick_and_idle();
        check("t5_dis_strobe", cnt_strobe, s);
        check("t5_dis_overrun", ovr[0], 1'b0);
        enable = 1'b1;

        // overrun: second tick two cycles after a row tick
        repeat (5) tick_and_idle();
        s = cnt_strobe;
        pulse_tick();
        cyc();
        pulse_tick();
        @(negedge clk);
        check("t5_overrun_set", ovr[0], 1'b1);
        repeat (10) cyc();
        check("t5_overrun_sticky", ovr[0], 1'b1);
        check("t5_one_strobe", cnt_strobe, s + 1);

        // restart with a coincident tick
        s = cnt_strobe;
        restart = 1'b1; frame_tick = 1'b1;
        cyc();
        restart = 1'b0; frame_tick = 1'b0;
        @(negedge clk);
        check("t6_restart_row", row[0], 8'h00);
        repeat (4) cyc();
        check("t6_restart_nostrobe", cnt_strobe, s);

        // async reset in READ_ROW
        pulse_tick();
        cyc();
        rst_n = 1'b0;
        #1;
        check("t6_rst_addr", rom_addr[0], 8'h00);
        check("t6_rst_instr", instr[0], 4'h0);
        check("t6_rst_note", note[0], 6'h00);
        check("t6_rst_overrun", ovr[0], 1'b0);
        check("t6_rst_strobe", strobe[0], 1'b0);
        cyc();
        rst_n = 1'b1;
        cyc();
        clear_tallies();
        tick_and_idle();
        check("t6_post_rst_addr", last_addr, 8'h40);
        check("t6_post_rst_loads", cnt_load, 1);

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            frame_tick = ($urandom_range(0, 3) == 0);
            enable     = ($urandom_range(0, 7) != 0);
            restart    = ($urandom_range(0, 63) == 0);
            rst_n      = ($urandom_range(0, 499) != 0);
            cyc();
        end
        rst_n = 1'b1; frame_tick = 1'b0; restart = 1'b0;
        repeat (8) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
